// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared constants and the request bundle for the bus memory responder.
//   READ_DATA_OOR : data returned for a read that falls outside the memory
//   BYTE_LANES    : byte lanes per bus word
//   bus_req_t     : one bus request as presented by the initiator
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int          BYTE_LANES    = 4;
    localparam logic [31:0] READ_DATA_OOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0]           address;
        logic [BYTE_LANES-1:0] byte_enable;
        logic [31:0]           write_data;
        logic                  read;
        logic                  write;
    } bus_req_t;

endpackage

// File: rtl/bus_read_pipe.sv
// -----------------------------------------------------------------------------
// bus_read_pipe
// Fixed-latency return path for read data. A word loaded on the acceptance
// edge appears on out_valid_o/out_data_o LATENCY-1 edges later, i.e. the
// initiator samples it on the LATENCY-th edge after acceptance.
// Ports:
//   clock_i     : clock, rising edge
//   reset_n_i   : asynchronous active-low reset
//   in_valid_i  : a read is accepted on this edge
//   in_data_i   : word sampled at acceptance
//   out_valid_o : response valid (one cycle per accepted read)
//   out_data_o  : response data, holds its value while out_valid_o is low
// -----------------------------------------------------------------------------
module bus_read_pipe #(
    parameter int LATENCY = 2
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        in_valid_i,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o
);

    logic [LATENCY-1:0] valid_q;
    logic [31:0]        data_q [LATENCY];

    // Shift register; data stages only load behind a valid bit so the last
    // stage keeps the previous response between pulses.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= 32'h0000_0000;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/bus_memory_responder.sv
// -----------------------------------------------------------------------------
// bus_memory_responder
// Responder end of the core bus: word-addressed on-chip memory with a
// wait_req/valid handshake, per-lane write enables, configurable wait states
// and a pipelined fixed read latency.
// Ports:
//   clock, reset_n     : clock and asynchronous active-low reset
//   bus_address        : byte address, bits [1:0] ignored
//   bus_read_enable    : read request
//   bus_write_enable   : write request (wins when both enables are high)
//   bus_byte_enable    : write lane mask
//   bus_write_data     : lane-aligned write data
//   bus_wait_req       : request not accepted this cycle (combinational)
//   bus_valid          : read response present this cycle
//   bus_read_data      : read response data
//   protocol_error     : sticky; both enables, or out-of-range access
// -----------------------------------------------------------------------------
module bus_memory_responder
    import bus_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 10,
    parameter logic [31:0] BASE_ADDRESS    = 32'h0000_0000,
    parameter int          READ_LATENCY    = 2,
    parameter int          WAIT_CYCLES     = 0,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] bus_address,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    input  logic [3:0]  bus_byte_enable,
    input  logic [31:0] bus_write_data,
    output logic        bus_wait_req,
    output logic        bus_valid,
    output logic [31:0] bus_read_data,
    output logic        protocol_error
);

    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int TAG_LSB = ADDR_WIDTH + 2;
    localparam int WCW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int OCW     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(WAIT_CYCLES);
    localparam logic [OCW-1:0] OUT_LIMIT  = OCW'(MAX_OUTSTANDING);

    logic [31:0]           mem_q [DEPTH];
    bus_req_t              req_s;
    logic                  req_any_s;
    logic                  rd_only_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  wait_req_s;
    logic                  accept_s;
    logic                  rd_accept_s;
    logic                  wr_accept_s;
    logic [31:0]           rd_word_s;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [OCW-1:0]        outstanding_q, outstanding_d;
    logic                  error_q, error_d;
    logic                  unused_addr_lsb_s;

    assign unused_addr_lsb_s = ^bus_address[1:0];

    // Request decode, handshake and next-state for counters and error flag.
    always_comb begin
        req_s.address     = bus_address;
        req_s.byte_enable = bus_byte_enable;
        req_s.write_data  = bus_write_data;
        req_s.read        = bus_read_enable;
        req_s.write       = bus_write_enable;

        req_any_s  = req_s.read | req_s.write;
        // Both enables high is treated as a write, so only a pure read is a read.
        rd_only_s  = req_s.read & ~req_s.write;
        in_range_s = (req_s.address[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
        idx_s      = req_s.address[TAG_LSB-1:2];

        // A response leaving on this edge frees its slot on the same edge, so a
        // full pipe still accepts a read while bus_valid is high.
        wait_req_s = req_any_s &
                     ((wait_cnt_q != WAIT_LIMIT) |
                      (rd_only_s & (outstanding_q == OUT_LIMIT) & ~bus_valid));

        accept_s    = req_any_s & ~wait_req_s;
        rd_accept_s = accept_s & rd_only_s;
        wr_accept_s = accept_s & req_s.write & in_range_s;
        rd_word_s   = in_range_s ? mem_q[idx_s] : READ_DATA_OOR;

        if (!req_any_s) begin
            wait_cnt_d = '0;
        end else if (accept_s) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        case ({rd_accept_s, bus_valid})
            2'b10:   outstanding_d = outstanding_q + OCW'(1);
            2'b01:   outstanding_d = outstanding_q - OCW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        error_d = error_q | (accept_s & (~in_range_s | (req_s.read & req_s.write)));
    end

    // Control state: wait counter, outstanding reads, sticky error.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q    <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            outstanding_q <= outstanding_d;
            error_q       <= error_d;
        end
    end

    // Memory array: lane-masked writes, contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_accept_s) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (req_s.byte_enable[i]) begin
                    mem_q[idx_s][8*i +: 8] <= req_s.write_data[8*i +: 8];
                end
            end
        end
    end

    bus_read_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clock_i     (clock),
        .reset_n_i   (reset_n),
        .in_valid_i  (rd_accept_s),
        .in_data_i   (rd_word_s),
        .out_valid_o (bus_valid),
        .out_data_o  (bus_read_data)
    );

    assign bus_wait_req   = wait_req_s;
    assign protocol_error = error_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_memory_responder
// Three responders share clock and reset:
//   inst 0 : defaults (LAT=2, no wait states, 4 outstanding)
//   inst 1 : WAIT_CYCLES=3
//   inst 2 : READ_LATENCY=4, MAX_OUTSTANDING=2
// Reads push {instance, data, sample cycle} into a scoreboard; a monitor pops
// and compares whenever any bus_valid is high.
// -----------------------------------------------------------------------------
module tb_bus_memory_responder;

    logic        clk;
    logic        rst_n;
    logic        rd    [3];
    logic        wr    [3];
    logic        wreq  [3];
    logic        vld   [3];
    logic        perr  [3];
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rdata [3];
    logic [3:0]  be    [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    bus_memory_responder u_dut0 (
        .clock(clk), .reset_n(rst_n), .bus_address(addr[0]), .bus_read_enable(rd[0]),
        .bus_write_enable(wr[0]), .bus_byte_enable(be[0]), .bus_write_data(wd[0]),
        .bus_wait_req(wreq[0]), .bus_valid(vld[0]), .bus_read_data(rdata[0]),
        .protocol_error(perr[0]));

    bus_memory_responder #(.WAIT_CYCLES(3)) u_dut1 (
        .clock(clk), .reset_n(rst_n), .bus_address(addr[1]), .bus_read_enable(rd[1]),
        .bus_write_enable(wr[1]), .bus_byte_enable(be[1]), .bus_write_data(wd[1]),
        .bus_wait_req(wreq[1]), .bus_valid(vld[1]), .bus_read_data(rdata[1]),
        .protocol_error(perr[1]));

    bus_memory_responder #(.READ_LATENCY(4), .MAX_OUTSTANDING(2)) u_dut2 (
        .clock(clk), .reset_n(rst_n), .bus_address(addr[2]), .bus_read_enable(rd[2]),
        .bus_write_enable(wr[2]), .bus_byte_enable(be[2]), .bus_write_data(wd[2]),
        .bus_wait_req(wreq[2]), .bus_valid(vld[2]), .bus_read_data(rdata[2]),
        .protocol_error(perr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 2) ? 4 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: inst %0d data %h, required no response", i, rdata[i]);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("resp_inst", 32'(i), 32'(mon_e.inst));
                    check("resp_data", rdata[i], mon_e.data);
                    check("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    // Present a request at a negedge, wait for acceptance, return at the
    // negedge after the accepting edge. Reads push their expectation: valid is
    // visible in the cycle before edge acc+LAT.
    task automatic do_req(input int idx, input logic r, input logic w,
                          input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                          input logic [31:0] exp_d, output int waits, output int acc);
        rd[idx] = r; wr[idx] = w; addr[idx] = a; be[idx] = b; wd[idx] = d;
        waits = 0;
        #1;
        while (wreq[idx] === 1'b1 && waits < 20) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (wreq[idx] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: inst %0d wait_req %b, required 0", idx, wreq[idx]);
        end
        acc = cyc + 1;
        if (r && !w) sb_q.push_back('{idx, exp_d, acc + lat_of(idx) - 1});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int idx);
        rd[idx] = 1'b0;
        wr[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, a, a1;
        logic [31:0] vals [4];
        vals[0] = 32'h0102_0304; vals[1] = 32'h1122_3344;
        vals[2] = 32'h5566_7788; vals[3] = 32'h99AA_BBCC;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'h0; wd[i] = 32'h0; be[i] = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset_valid", {31'h0, vld[i]}, 32'h0);
            check("reset_rdata", rdata[i], 32'h0);
            check("reset_perr", {31'h0, perr[i]}, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read, no waits, LAT=2.
        do_req(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'hAABB_CCDD, 32'h0, w, a);
        check("t1_write_waits", 32'(w), 32'd0);
        do_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hAABB_CCDD, w, a);
        check("t1_read_waits", 32'(w), 32'd0);
        idle(0);
        repeat (4) @(negedge clk);

        // Single-lane write merges into the existing word.
        do_req(0, 1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000_5500, 32'h0, w, a);
        do_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hAABB_55DD, w, a);
        idle(0);
        repeat (4) @(negedge clk);

        // Four writes then four back-to-back reads, one per cycle.
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b0, 1'b1, 32'(4*i), 4'hF, vals[i], 32'h0, w, a);
        end
        for (int i = 0; i < 4; i++) begin
            do_req(0, 1'b1, 1'b0, 32'(4*i), 4'h0, 32'h0, vals[i], w, a);
            check("b2b_read_waits", 32'(w), 32'd0);
        end
        idle(0);
        repeat (4) @(negedge clk);

        // Out-of-range read returns zero; out-of-range write is dropped.
        check("perr_before_oor", {31'h0, perr[0]}, 32'h0);
        do_req(0, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, w, a);
        idle(0);
        check("perr_after_oor_read", {31'h0, perr[0]}, 32'h1);
        do_req(0, 1'b0, 1'b1, 32'h1010, 4'hF, 32'hDEAD_BEEF, 32'h0, w, a);
        do_req(0, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hAABB_55DD, w, a);
        idle(0);
        repeat (4) @(negedge clk);

        // Three wait states on every request.
        check("perr1_initial", {31'h0, perr[1]}, 32'h0);
        do_req(1, 1'b0, 1'b1, 32'h20, 4'hF, 32'h1234_5678, 32'h0, w, a);
        check("wait3_write_waits", 32'(w), 32'd3);
        do_req(1, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 32'h1234_5678, w, a);
        check("wait3_read_waits", 32'(w), 32'd3);
        // Both enables: a write, no response, error raised.
        do_req(1, 1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 32'h0, w, a);
        check("both_waits", 32'(w), 32'd3);
        check("both_perr", {31'h0, perr[1]}, 32'h1);
        do_req(1, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFE_F00D, w, a);
        idle(1);
        repeat (6) @(negedge clk);

        // Two outstanding, latency 4: third read waits for the first response.
        do_req(2, 1'b0, 1'b1, 32'h0, 4'hF, 32'h0F0F_0F0F, 32'h0, w, a);
        do_req(2, 1'b0, 1'b1, 32'h4, 4'hF, 32'hF0F0_F0F0, 32'h0, w, a);
        do_req(2, 1'b0, 1'b1, 32'h8, 4'hF, 32'h3C3C_A5A5, 32'h0, w, a);
        do_req(2, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0F0F_0F0F, w, a1);
        check("max_rd1_waits", 32'(w), 32'd0);
        do_req(2, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 32'hF0F0_F0F0, w, a);
        check("max_rd2_waits", 32'(w), 32'd0);
        do_req(2, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h3C3C_A5A5, w, a);
        check("max_rd3_waits", 32'(w), 32'd2);
        check("max_rd3_accept_edge", 32'(a - a1), 32'd4);
        idle(2);
        repeat (8) @(negedge clk);

        // Reset with two reads in flight: responses dropped.
        do_req(2, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0F0F_0F0F, w, a);
        do_req(2, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 32'hF0F0_F0F0, w, a);
        idle(2);
        rst_n = 1'b0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        check("rst_flight_valid", {31'h0, vld[2]}, 32'h0);
        check("rst_flight_rdata", rdata[2], 32'h0);
        check("rst_perr_cleared", {31'h0, perr[0]}, 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        // Outstanding must be back to zero: two reads accepted without stalls.
        do_req(2, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h3C3C_A5A5, w, a);
        check("post_rst_rd1_waits", 32'(w), 32'd0);
        do_req(2, 1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 32'hF0F0_F0F0, w, a);
        check("post_rst_rd2_waits", 32'(w), 32'd0);
        idle(2);
        repeat (8) @(negedge clk);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
